// File: rtl/core_run_ctrl.sv
// Host-side sequencer for the 4-thread barrel RISC-V datapath: loads imem/dmem,
// runs the core until a mailbox store or a cycle-budget timeout, and reports status.
module core_run_ctrl #(
   parameter int           D_WIDTH         = 64,
   parameter int           ISTR_WIDTH      = 32,
   parameter logic [9:0]   DONE_ADDR       = 10'h3FC,
   parameter int           CORE_RST_CYCLES = 2,
   parameter int           DRAIN_CYCLES    = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [1:0]             cmd_op,
   input  logic [8:0]             cmd_addr,
   input  logic [D_WIDTH-1:0]     cmd_data,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [1:0]             rsp_code,
   output logic [D_WIDTH-1:0]     rsp_data,
   output logic                   busy,
   output logic [31:0]            cycle_count,
   output logic                   core_reset_n,
   output logic                   pc_en,
   output logic [31:0]            i_mem_addra,
   output logic [ISTR_WIDTH-1:0]  i_mem_din,
   output logic                   i_mem_we,
   output logic [7:0]             d_mem_addra,
   output logic [D_WIDTH-1:0]     d_mem_din,
   output logic                   d_mem_we,
   input  logic [D_WIDTH-1:0]     d_mem_out,
   input  logic                   mem_we,
   input  logic [9:0]             mem_addr_out,
   input  logic [63:0]            mem_data_out
);

   typedef enum logic [2:0] {
      IDLE, WR, RD_ADDR, RD_CAP, CRST, RUN, DRAIN, RSP
   } state_t;

   localparam logic [1:0] OP_WRITE_I = 2'b00;
   localparam logic [1:0] OP_WRITE_D = 2'b01;
   localparam logic [1:0] OP_RUN     = 2'b10;
   localparam logic [1:0] OP_READ_D  = 2'b11;

   localparam logic [1:0] RSP_READ    = 2'b00;
   localparam logic [1:0] RSP_DONE    = 2'b01;
   localparam logic [1:0] RSP_TIMEOUT = 2'b10;

   localparam int          CNT_W        = 8;
   localparam logic [CNT_W-1:0] CRST_LAST  = CNT_W'(CORE_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [31:0]             budget_q, budget_d;
   logic [31:0]             cycle_count_q, cycle_count_d;
   logic                    cmd_ready_q, cmd_ready_d;
   logic                    busy_q, busy_d;
   logic                    core_reset_n_q, core_reset_n_d;
   logic                    pc_en_q, pc_en_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic [1:0]              rsp_code_q, rsp_code_d;
   logic [D_WIDTH-1:0]      rsp_data_q, rsp_data_d;
   logic [31:0]             i_mem_addra_q, i_mem_addra_d;
   logic [ISTR_WIDTH-1:0]   i_mem_din_q, i_mem_din_d;
   logic                    i_mem_we_q, i_mem_we_d;
   logic [7:0]              d_mem_addra_q, d_mem_addra_d;
   logic [D_WIDTH-1:0]      d_mem_din_q, d_mem_din_d;
   logic                    d_mem_we_q, d_mem_we_d;

   logic                    run_done;
   logic                    run_timeout;

   assign run_done    = mem_we && (mem_addr_out == DONE_ADDR);
   assign run_timeout = (budget_q != 32'd0) && (cycle_count_q == budget_q);

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      budget_d       = budget_q;
      cycle_count_d  = cycle_count_q;
      rsp_code_d     = rsp_code_q;
      rsp_data_d     = rsp_data_q;
      i_mem_addra_d  = i_mem_addra_q;
      i_mem_din_d    = i_mem_din_q;
      i_mem_we_d     = 1'b0;
      d_mem_addra_d  = d_mem_addra_q;
      d_mem_din_d    = d_mem_din_q;
      d_mem_we_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               case (cmd_op)
                  OP_WRITE_I: begin
                     i_mem_we_d    = 1'b1;
                     i_mem_addra_d = {23'b0, cmd_addr};
                     i_mem_din_d   = cmd_data[ISTR_WIDTH-1:0];
                     state_d       = WR;
                  end
                  OP_WRITE_D: begin
                     d_mem_we_d    = 1'b1;
                     d_mem_addra_d = cmd_addr[7:0];
                     d_mem_din_d   = cmd_data;
                     state_d       = WR;
                  end
                  OP_READ_D: begin
                     d_mem_addra_d = cmd_addr[7:0];
                     state_d       = RD_ADDR;
                  end
                  OP_RUN: begin
                     budget_d      = cmd_data[31:0];
                     cycle_count_d = 32'd0;
                     cnt_d         = '0;
                     state_d       = CRST;
                  end
                  default: state_d = IDLE;
               endcase
            end
         end
         WR:      state_d = IDLE;
         RD_ADDR: state_d = RD_CAP;
         RD_CAP: begin
            rsp_data_d = d_mem_out;
            rsp_code_d = RSP_READ;
            state_d    = RSP;
         end
         CRST: begin
            if (cnt_q == CRST_LAST) begin
               // The first RUN cycle is counted as cycle 1, so the counter
               // equals the number of fetch-enabled cycles seen so far.
               cycle_count_d = 32'd1;
               state_d       = RUN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RUN: begin
            if (run_done) begin
               rsp_code_d = RSP_DONE;
               rsp_data_d = D_WIDTH'(mem_data_out);
               cnt_d      = '0;
               state_d    = DRAIN;
            end else if (run_timeout) begin
               rsp_code_d = RSP_TIMEOUT;
               rsp_data_d = D_WIDTH'(cycle_count_q);
               cnt_d      = '0;
               state_d    = DRAIN;
            end else if (cycle_count_q != 32'hFFFF_FFFF) begin
               cycle_count_d = cycle_count_q + 32'd1;
            end
         end
         DRAIN: begin
            if (cnt_q == DRAIN_LAST) begin
               state_d = RSP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RSP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Status outputs are a pure function of the next state, registered below.
      cmd_ready_d    = (state_d == IDLE);
      busy_d         = (state_d != IDLE);
      core_reset_n_d = (state_d == RUN) || (state_d == DRAIN);
      pc_en_d        = (state_d == RUN);
      rsp_valid_d    = (state_d == RSP);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         budget_q       <= 32'd0;
         cycle_count_q  <= 32'd0;
         cmd_ready_q    <= 1'b1;
         busy_q         <= 1'b0;
         core_reset_n_q <= 1'b0;
         pc_en_q        <= 1'b0;
         rsp_valid_q    <= 1'b0;
         rsp_code_q     <= 2'b00;
         rsp_data_q     <= '0;
         i_mem_addra_q  <= 32'd0;
         i_mem_din_q    <= '0;
         i_mem_we_q     <= 1'b0;
         d_mem_addra_q  <= 8'd0;
         d_mem_din_q    <= '0;
         d_mem_we_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         budget_q       <= budget_d;
         cycle_count_q  <= cycle_count_d;
         cmd_ready_q    <= cmd_ready_d;
         busy_q         <= busy_d;
         core_reset_n_q <= core_reset_n_d;
         pc_en_q        <= pc_en_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_code_q     <= rsp_code_d;
         rsp_data_q     <= rsp_data_d;
         i_mem_addra_q  <= i_mem_addra_d;
         i_mem_din_q    <= i_mem_din_d;
         i_mem_we_q     <= i_mem_we_d;
         d_mem_addra_q  <= d_mem_addra_d;
         d_mem_din_q    <= d_mem_din_d;
         d_mem_we_q     <= d_mem_we_d;
      end
   end

   assign cmd_ready    = cmd_ready_q;
   assign busy         = busy_q;
   assign cycle_count  = cycle_count_q;
   assign core_reset_n = core_reset_n_q;
   assign pc_en        = pc_en_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_code     = rsp_code_q;
   assign rsp_data     = rsp_data_q;
   assign i_mem_addra  = i_mem_addra_q;
   assign i_mem_din    = i_mem_din_q;
   assign i_mem_we     = i_mem_we_q;
   assign d_mem_addra  = d_mem_addra_q;
   assign d_mem_din    = d_mem_din_q;
   assign d_mem_we     = d_mem_we_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl: memory loads, readback, mailbox/timeout runs,
// and reset abort, with a simple 1-cycle-latency dmem model on port B.
module tb_core_run_ctrl;

   localparam logic [9:0] DONE_ADDR = 10'h3FC;

   logic        clk;
   logic        reset_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [8:0]  cmd_addr;
   logic [63:0] cmd_data;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_code;
   logic [63:0] rsp_data;
   logic        busy;
   logic [31:0] cycle_count;
   logic        core_reset_n;
   logic        pc_en;
   logic [31:0] i_mem_addra;
   logic [31:0] i_mem_din;
   logic        i_mem_we;
   logic [7:0]  d_mem_addra;
   logic [63:0] d_mem_din;
   logic        d_mem_we;
   logic [63:0] d_mem_out;
   logic        mem_we;
   logic [9:0]  mem_addr_out;
   logic [63:0] mem_data_out;

   int vectors;
   int miscompares;

   logic [63:0] dmem [0:255];

   core_run_ctrl dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_op       (cmd_op),
      .cmd_addr     (cmd_addr),
      .cmd_data     (cmd_data),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_code     (rsp_code),
      .rsp_data     (rsp_data),
      .busy         (busy),
      .cycle_count  (cycle_count),
      .core_reset_n (core_reset_n),
      .pc_en        (pc_en),
      .i_mem_addra  (i_mem_addra),
      .i_mem_din    (i_mem_din),
      .i_mem_we     (i_mem_we),
      .d_mem_addra  (d_mem_addra),
      .d_mem_din    (d_mem_din),
      .d_mem_we     (d_mem_we),
      .d_mem_out    (d_mem_out),
      .mem_we       (mem_we),
      .mem_addr_out (mem_addr_out),
      .mem_data_out (mem_data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Port-B data memory: write-then-register-read, one cycle of read latency.
   always @(posedge clk) begin
      if (d_mem_we) dmem[d_mem_addra] <= d_mem_din;
      d_mem_out <= dmem[d_mem_addra];
   end

   // Called at a negedge; returns at the negedge one cycle after acceptance.
   task automatic send_cmd(input logic [1:0] op, input logic [8:0] addr,
                           input logic [63:0] data, output int waited);
      waited    = 0;
      cmd_op    = op;
      cmd_addr  = addr;
      cmd_data  = data;
      cmd_valid = 1'b1;
      while (!cmd_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      vectors++;
      if (waited >= 50) begin
         miscompares++;
         $display("[TB] FAIL cmd_accept_timeout: waited %0d cycles, required < 50", waited);
      end
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   // Runs one RUN command with a modelled core; stops at the negedge where rsp_valid rises.
   task automatic do_run(input logic [31:0] budget, input int store_at,
                         input logic [63:0] store_data, input bit drain_store,
                         output int crst_n, output int run_n, output int drain_n,
                         output logic crn_in_run);
      int w;
      send_cmd(2'b10, 9'd0, {32'b0, budget}, w);
      crst_n = 0;
      while (!pc_en && crst_n < 10) begin
         crst_n++;
         @(negedge clk);
      end
      crn_in_run = core_reset_n;
      run_n = 0;
      while (pc_en && run_n < 500) begin
         run_n++;
         if (run_n == 3) begin
            mem_we = 1'b1; mem_addr_out = DONE_ADDR - 10'd1; mem_data_out = 64'hBAD;
         end
         if (run_n == store_at) begin
            mem_we = 1'b1; mem_addr_out = DONE_ADDR; mem_data_out = store_data;
         end
         @(negedge clk);
         mem_we = 1'b0;
      end
      drain_n = 0;
      while (!rsp_valid && drain_n < 20) begin
         drain_n++;
         if (drain_store && drain_n == 2) begin
            mem_we = 1'b1; mem_addr_out = DONE_ADDR; mem_data_out = 64'h99;
         end
         @(negedge clk);
         mem_we = 1'b0;
      end
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      vectors++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_status: got ready=%b busy=%b rspv=%b, required 1 0 0", cmd_ready, busy, rsp_valid);
      end
      vectors++;
      if (pc_en !== 1'b0 || core_reset_n !== 1'b0 || i_mem_we !== 1'b0 || d_mem_we !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_core: got pc_en=%b crn=%b iwe=%b dwe=%b, required 0 0 0 0", pc_en, core_reset_n, i_mem_we, d_mem_we);
      end
      vectors++;
      if (cycle_count !== 32'd0 || i_mem_addra !== 32'd0 || d_mem_addra !== 8'd0 || rsp_data !== 64'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_data: got cc=%h ia=%h da=%h rd=%h, required all zero", cycle_count, i_mem_addra, d_mem_addra, rsp_data);
      end
      reset_n = 1'b1;
      @(negedge clk);
      vectors++;
      if (cmd_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL reset_release_ready: got %b, required 1", cmd_ready);
      end
   endtask

   task automatic test_write_i;
      int w;
      send_cmd(2'b00, 9'd5, 64'h0000_0000_0050_0093, w);
      vectors++;
      if (i_mem_we !== 1'b1 || i_mem_addra !== 32'd5 || i_mem_din !== 32'h0050_0093) begin
         miscompares++;
         $display("[TB] FAIL write_i_strobe: got we=%b a=%h d=%h, required 1 00000005 00500093", i_mem_we, i_mem_addra, i_mem_din);
      end
      vectors++;
      if (cmd_ready !== 1'b0 || busy !== 1'b1 || d_mem_we !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL write_i_busy: got ready=%b busy=%b dwe=%b, required 0 1 0", cmd_ready, busy, d_mem_we);
      end
      @(negedge clk);
      vectors++;
      if (i_mem_we !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL write_i_done: got we=%b ready=%b busy=%b, required 0 1 0", i_mem_we, cmd_ready, busy);
      end
   endtask

   task automatic test_back_to_back;
      int w;
      send_cmd(2'b00, 9'h1FF, 64'h1111_2222_3333_4444, w);
      send_cmd(2'b00, 9'd8, 64'h0000_0000_ABCD_0123, w);
      vectors++;
      if (w !== 1) begin
         miscompares++;
         $display("[TB] FAIL b2b_gap: got wait %0d, required 1", w);
      end
      vectors++;
      if (i_mem_we !== 1'b1 || i_mem_addra !== 32'd8 || i_mem_din !== 32'hABCD_0123) begin
         miscompares++;
         $display("[TB] FAIL b2b_second: got we=%b a=%h d=%h, required 1 00000008 abcd0123", i_mem_we, i_mem_addra, i_mem_din);
      end
      @(negedge clk);
   endtask

   task automatic test_write_read_d;
      int w;
      send_cmd(2'b01, 9'h1A3, 64'hDEADBEEF_CAFEF00D, w);
      vectors++;
      if (d_mem_we !== 1'b1 || d_mem_addra !== 8'hA3 || d_mem_din !== 64'hDEADBEEF_CAFEF00D || i_mem_we !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL write_d_strobe: got we=%b a=%h d=%h iwe=%b, required 1 a3 deadbeefcafef00d 0", d_mem_we, d_mem_addra, d_mem_din, i_mem_we);
      end
      @(negedge clk);
      send_cmd(2'b11, 9'h0A3, 64'd0, w);
      vectors++;
      if (d_mem_addra !== 8'hA3 || d_mem_we !== 1'b0 || rsp_valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL read_d_addr: got a=%h we=%b rspv=%b, required a3 0 0", d_mem_addra, d_mem_we, rsp_valid);
      end
      @(negedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (rsp_valid !== 1'b1 || rsp_code !== 2'b00 || rsp_data !== 64'hDEADBEEF_CAFEF00D) begin
            miscompares++;
            $display("[TB] FAIL read_d_hold%0d: got v=%b c=%b d=%h, required 1 00 deadbeefcafef00d", i, rsp_valid, rsp_code, rsp_data);
         end
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      vectors++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL read_d_release: got v=%b ready=%b busy=%b, required 0 1 0", rsp_valid, cmd_ready, busy);
      end
   endtask

   task automatic test_run_done;
      int crst_n, run_n, drain_n;
      logic crn;
      do_run(32'd0, 40, 64'h1, 1'b0, crst_n, run_n, drain_n, crn);
      vectors++;
      if (crst_n !== 2 || run_n !== 40 || drain_n !== 4 || crn !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL run_done_timing: got crst=%0d run=%0d drain=%0d crn=%b, required 2 40 4 1", crst_n, run_n, drain_n, crn);
      end
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_code !== 2'b01 || rsp_data !== 64'h1 || cycle_count !== 32'd40) begin
         miscompares++;
         $display("[TB] FAIL run_done_rsp: got v=%b c=%b d=%h cc=%0d, required 1 01 1 40", rsp_valid, rsp_code, rsp_data, cycle_count);
      end
      vectors++;
      if (core_reset_n !== 1'b0 || pc_en !== 1'b0 || busy !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL run_done_rsp_core: got crn=%b pc_en=%b busy=%b, required 0 0 1", core_reset_n, pc_en, busy);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      vectors++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || cycle_count !== 32'd40) begin
         miscompares++;
         $display("[TB] FAIL run_done_release: got v=%b ready=%b cc=%0d, required 0 1 40", rsp_valid, cmd_ready, cycle_count);
      end
   endtask

   task automatic test_run_timeout;
      int crst_n, run_n, drain_n;
      logic crn;
      do_run(32'd100, 0, 64'h0, 1'b0, crst_n, run_n, drain_n, crn);
      vectors++;
      if (run_n !== 100 || drain_n !== 4) begin
         miscompares++;
         $display("[TB] FAIL timeout_timing: got run=%0d drain=%0d, required 100 4", run_n, drain_n);
      end
      vectors++;
      if (rsp_code !== 2'b10 || rsp_data !== 64'd100 || cycle_count !== 32'd100) begin
         miscompares++;
         $display("[TB] FAIL timeout_rsp: got c=%b d=%h cc=%0d, required 10 64 100", rsp_code, rsp_data, cycle_count);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_done_beats_timeout;
      int crst_n, run_n, drain_n, w;
      logic crn;
      do_run(32'd50, 50, 64'h7, 1'b1, crst_n, run_n, drain_n, crn);
      vectors++;
      if (run_n !== 50 || rsp_code !== 2'b01 || rsp_data !== 64'h7 || cycle_count !== 32'd50) begin
         miscompares++;
         $display("[TB] FAIL done_wins: got run=%0d c=%b d=%h cc=%0d, required 50 01 7 50", run_n, rsp_code, rsp_data, cycle_count);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      send_cmd(2'b10, 9'd0, 64'd0, w);
      vectors++;
      if (cycle_count !== 32'd0 || core_reset_n !== 1'b0 || busy !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL run_accept_clear: got cc=%0d crn=%b busy=%b, required 0 0 1", cycle_count, core_reset_n, busy);
      end
   endtask

   // Continues the unlimited run started by the previous task, then aborts it.
   task automatic test_reset_mid_run;
      int n;
      n = 0;
      while (!pc_en && n < 10) begin
         n++;
         @(negedge clk);
      end
      repeat (19) @(negedge clk);
      vectors++;
      if (pc_en !== 1'b1 || cycle_count !== 32'd20) begin
         miscompares++;
         $display("[TB] FAIL midrun_pre: got pc_en=%b cc=%0d, required 1 20", pc_en, cycle_count);
      end
      reset_n = 1'b0;
      #1;
      vectors++;
      if (pc_en !== 1'b0 || core_reset_n !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0 || cycle_count !== 32'd0) begin
         miscompares++;
         $display("[TB] FAIL midrun_abort: got pc_en=%b crn=%b busy=%b v=%b cc=%0d, required 0 0 0 0 0", pc_en, core_reset_n, busy, rsp_valid, cycle_count);
      end
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      vectors++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || pc_en !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL midrun_after: got ready=%b v=%b pc_en=%b, required 1 0 0", cmd_ready, rsp_valid, pc_en);
      end
   endtask

   initial begin
      vectors      = 0;
      miscompares  = 0;
      reset_n      = 1'b0;
      cmd_valid    = 1'b0;
      cmd_op       = 2'b00;
      cmd_addr     = 9'd0;
      cmd_data     = 64'd0;
      rsp_ready    = 1'b0;
      mem_we       = 1'b0;
      mem_addr_out = 10'd0;
      mem_data_out = 64'd0;
      test_reset();
      test_write_i();
      test_back_to_back();
      test_write_read_d();
      test_run_done();
      test_run_timeout();
      test_done_beats_timeout();
      test_reset_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/core_run_ctrl.md
Name: core_run_ctrl

Overview:
Host-facing sequencer for the 4-thread barrel RISC-V datapath. It loads instruction and data memories through the datapath's port-B/user write interfaces, and holds the core in reset while loading. It then releases the core, drives pc_en for a run, and detects program completion via a store to a mailbox address or a cycle-budget timeout. Finally it drains the pipeline and returns status, and it serves data-memory readback.

Parameters:
D_WIDTH, 64, data word width
ISTR_WIDTH, 32, instruction width
DONE_ADDR, 10'h3FC, mailbox address; a core store here ends the run
CORE_RST_CYCLES, 2, cycles core_reset_n is held low before RUN
DRAIN_CYCLES, 4, cycles pc_en is held low after run end before response

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  2  00 WRITE_I, 01 WRITE_D, 10 RUN, 11 READ_D
cmd_addr  in  9  word address (imem 9b, dmem uses [7:0])
cmd_data  in  D_WIDTH  write data; RUN: [31:0] cycle budget, 0 = unlimited
rsp_valid  out  1  response valid
rsp_ready  in  1  host accepts response
rsp_code  out  2  00 read data, 01 done, 10 timeout
rsp_data  out  D_WIDTH  response payload
busy  out  1  high in any state except IDLE
cycle_count  out  32  RUN cycles of last/current run
core_reset_n  out  1  synchronous reset to datapath, active low
pc_en  out  1  datapath fetch enable
i_mem_addra  out  32  imem write address (word index, zero-extended)
i_mem_din  out  ISTR_WIDTH  imem write data
i_mem_we  out  1  imem write strobe
d_mem_addra  out  8  dmem port-B address
d_mem_din  out  D_WIDTH  dmem port-B write data
d_mem_we  out  1  dmem port-B write strobe
d_mem_out  in  D_WIDTH  dmem port-B read data, 1-cycle latency
mem_we  in  1  core store strobe (MEM stage)
mem_addr_out  in  10  core store address
mem_data_out  in  64  core store data

Behaviour:
- States: IDLE, WR, RD_ADDR, RD_CAP, CRST, RUN, DRAIN, RSP. All outputs are registered.
- Async reset (any state, including mid-run):
  - state IDLE; pc_en, i_mem_we, d_mem_we, rsp_valid, busy all 0.
  - core_reset_n 0; cycle_count 0; all address/data outputs 0.
  - No response is issued for an aborted operation.
- cmd_ready=1 only in IDLE (1 on the first cycle after reset).
- core_reset_n=1 only in RUN and DRAIN. It is 0 in all other states, so the core is held in reset whenever it is not running.
- WRITE_I accept:
  - Next cycle (WR): i_mem_we=1 for exactly 1 cycle, i_mem_addra={23'b0,cmd_addr}, i_mem_din=cmd_data[31:0].
  - Then IDLE. The next accept is possible 2 cycles after the previous one.
- WRITE_D accept: same as WRITE_I on the dmem port. d_mem_addra=cmd_addr[7:0], cmd_addr[8] is ignored, d_mem_din=cmd_data.
- READ_D accept:
  - RD_ADDR drives d_mem_addra.
  - RD_CAP captures d_mem_out into rsp_data.
  - RSP: rsp_valid=1, rsp_code=00.
- RUN accept:
  - Latch the budget and clear cycle_count.
  - CRST lasts CORE_RST_CYCLES cycles, then RUN.
- RUN state:
  - pc_en=1; cycle_count increments each cycle and saturates at 32'hFFFFFFFF.
  - Done: mem_we=1 and mem_addr_out==DONE_ADDR → DRAIN, rsp_code=01, rsp_data=mem_data_out.
  - Timeout: budget!=0 and cycle_count==budget → DRAIN, rsp_code=10, rsp_data={32'b0,cycle_count}.
  - Done and timeout in the same cycle: done wins.
- DRAIN state:
  - pc_en=0 for DRAIN_CYCLES cycles.
  - Mailbox stores during DRAIN are ignored; the captured rsp_data is not overwritten.
  - Then RSP.
- RSP: rsp_valid held with stable data/code until rsp_ready=1. The cycle after the handshake: IDLE, rsp_valid=0.
- busy=1 outside IDLE. cycle_count holds its value after the run until the next RUN accept.
- cmd_valid with an unaccepted command is ignored (no queue). The host must hold cmd_valid until it sees cmd_ready.

Test Plan:
- After reset, WRITE_I addr 5 data 32'h00500093 → one-cycle i_mem_we, i_mem_addra=5, i_mem_din=32'h00500093; cmd_ready returns 1 two cycles after accept.
- WRITE_D addr 9'h1A3 data 64'hDEADBEEF_CAFEF00D, then READ_D addr 8'hA3 → d_mem_addra=8'hA3; rsp_code=00, rsp_data=64'hDEADBEEF_CAFEF00D; rsp_valid held 3 cycles with rsp_ready=0, stable throughout.
- RUN budget 0; model a core store to 10'h3FC with data 64'h1 at RUN cycle 40 → core_reset_n low for 2 cycles, pc_en high for 40 cycles, then low for 4; rsp_code=01, rsp_data=1, cycle_count=40.
- RUN budget 100 with no mailbox store → DRAIN entered when cycle_count=100; rsp_code=10, rsp_data=100.
- RUN budget 50 with mailbox store data 7 exactly at cycle_count=50 → rsp_code=01, rsp_data=7. A second mailbox store during DRAIN leaves rsp_data=7.
- Assert reset_n low mid-RUN at cycle 20 → immediately pc_en=0, core_reset_n=0, busy=0, no rsp_valid; after release, cmd_ready=1.
